mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory-adapter port (65-bit mem_cmd FIFO, mem_write and mem_read streams) among
//  num_ports requesters inside da_platform, e.g. per-slot sample buffers and host transfer logic.
//  Round-robin grant held for a whole burst: command issue, then exactly len write or read beats.
//  Sits between requesters and the memory adapter's ext_mem_cmd/ext_mem_write/ext_mem_read ports.
// PARAMETERS
//  num_ports  4   number of requesters (2..8)
//  mem_width  32  data word width, bits
// PORTS
//  clk             in   1             memory-domain clock; all logic on rising edge
//  reset           in   1             asynchronous, active-high
//  req_valid       in   num_ports     command request per port
//  req_ready       out  num_ports     command accepted (one-hot, one cycle)
//  req_write       in   num_ports     1 = write burst, 0 = read burst
//  req_addr        in   32*num_ports  word address, port i at [32*i +: 32]
//  req_len         in   32*num_ports  burst length in words, port i at [32*i +: 32]
//  wr_valid        in   num_ports     write data valid per port
//  wr_data         in   mem_width*num_ports  write data per port
//  wr_ready        out  num_ports     write data accepted
//  rd_valid        out  num_ports     read data valid, only granted port
//  rd_data         out  mem_width     read data, shared by all ports
//  rd_ready        in   num_ports     read data accepted
//  mem_cmd_valid   out  1             to adapter; mem_cmd_data = {write, addr[31:0], len[31:0]}
//  mem_cmd_data    out  65
//  mem_cmd_ready   in   1
//  mem_write_valid out  1   /  mem_write_data out mem_width  /  mem_write_ready in 1
//  mem_read_valid  in   1   /  mem_read_data  in  mem_width  /  mem_read_ready  out 1
//  grant_id        out  $clog2(num_ports)  port holding the grant; valid while busy
//  busy            out  1             state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; req_ready, wr_ready, rd_valid, mem_*_valid, mem_read_ready, busy = 0;
//    grant_id = 0; rr pointer = num_ports-1 so port 0 wins first; beat counter = 0.
//  States IDLE -> ISSUE -> {WRITE | READ | IDLE}.
//  IDLE: if any req_valid, select first set bit scanning from rr_ptr+1 upward with wrap.
//    Assert req_ready[g] combinationally in that cycle. Latch cmd/len, grant_id=g, rr_ptr=g; -> ISSUE.
//    Grant to be issued next cycle (1-cycle latency).
//  ISSUE: mem_cmd_valid=1 with the latched word and held stable until mem_cmd_ready.
//    On the handshake: len==0 -> IDLE; write -> WRITE; read -> READ. Counter loads len.
//  WRITE: mem_write_valid=wr_valid[g]; mem_write_data=wr_data[g]; wr_ready[g]=mem_write_ready.
//    Other wr_ready bits = 0. On each beat (valid&ready) the counter decrements.
//    After the beat that takes it 1->0, go to IDLE.
//  READ: rd_valid[g]=mem_read_valid; rd_data=mem_read_data; mem_read_ready=rd_ready[g].
//    Other rd_valid bits = 0. Counter and exit rule are the same as WRITE.
//  All data paths are combinational pass-through: no added latency, no buffering, ready never depends on own valid.
//  Back-to-back: IDLE is visited for at least one cycle between bursts (grant decision cycle).
//  Ports that are not granted see req_ready=0 and may hold req_valid for any duration.
//  The requester must not change its command while waiting.
//  Ungranted ports' wr_valid/rd_ready are ignored. Stray mem_read_valid in IDLE/ISSUE/WRITE is not acked.
//  len is full 32-bit unsigned; counter never wraps (exit at 0).
//  Async reset mid-burst aborts to IDLE at once, and the adapter must be reset with it.
// TESTING
//  1 Port 1 only: write addr 0x100 len 4 -> mem_cmd_data={1,0x100,4}; 4 beats pass; busy falls after beat 4.
//  2 Ports 0,2,3 req together, repeated -> grant order 0,2,3,0,...; req_ready one-hot, one cycle each.
//  3 Read len 3, mem_cmd_ready low 5 cycles -> cmd held stable; then 3 beats to rd_data/rd_valid[g] only.
//  4 Stalls: write len 8 with random wr_valid/mem_write_ready gaps -> exactly 8 beats, data in order.
//  5 len 0 read on port 2 -> one mem_cmd handshake, no data beats, back to IDLE the next cycle.
//  6 Reset asserted mid-write on beat 2 of 6 -> all outputs 0 immediately; port 0 is granted first afterwards.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory-adapter command/write/read port among num_ports requesters.
// Latency: grant decided in IDLE, command issued the next cycle; data beats are combinational pass-through.
// Backpressure: mem_cmd held until mem_cmd_ready; beats follow the adapter's and the granted port's ready/valid.
module mem_port_arbiter #(
    parameter int num_ports = 4,
    parameter int mem_width = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_ports-1:0]           req_valid,
    output logic [num_ports-1:0]           req_ready,
    input  logic [num_ports-1:0]           req_write,
    input  logic [32*num_ports-1:0]        req_addr,
    input  logic [32*num_ports-1:0]        req_len,
    input  logic [num_ports-1:0]           wr_valid,
    input  logic [mem_width*num_ports-1:0] wr_data,
    output logic [num_ports-1:0]           wr_ready,
    output logic [num_ports-1:0]           rd_valid,
    output logic [mem_width-1:0]           rd_data,
    input  logic [num_ports-1:0]           rd_ready,
    output logic                           mem_cmd_valid,
    output logic [64:0]                    mem_cmd_data,
    input  logic                           mem_cmd_ready,
    output logic                           mem_write_valid,
    output logic [mem_width-1:0]           mem_write_data,
    input  logic                           mem_write_ready,
    input  logic                           mem_read_valid,
    input  logic [mem_width-1:0]           mem_read_data,
    output logic                           mem_read_ready,
    output logic [$clog2(num_ports)-1:0]   grant_id,
    output logic                           busy
);
    localparam int id_w = $clog2(num_ports);

    typedef enum logic [1:0] {IDLE, ISSUE, WRITE, READ} state_t;

    state_t          state;
    logic [id_w-1:0] rr_ptr;
    logic [31:0]     beat_cnt;
    logic [64:0]     cmd_word;
    logic            sel_found;
    logic [id_w-1:0] sel_id;
    int              sel_idx;

    // First requester strictly after the last grant, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        sel_idx   = 0;
        for (int k = 1; k <= num_ports; k++) begin
            sel_idx = (int'(rr_ptr) + k) % num_ports;
            if (!sel_found && req_valid[sel_idx]) begin
                sel_found = 1'b1;
                sel_id    = id_w'(sel_idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        wr_ready  = '0;
        rd_valid  = '0;
        if (state == IDLE && sel_found && !reset)
            req_ready[sel_id] = 1'b1;
        if (state == WRITE)
            wr_ready[grant_id] = mem_write_ready;
        if (state == READ)
            rd_valid[grant_id] = mem_read_valid;
    end

    assign mem_cmd_valid   = (state == ISSUE);
    assign mem_cmd_data    = cmd_word;
    assign mem_write_valid = (state == WRITE) && wr_valid[grant_id];
    assign mem_write_data  = wr_data[int'(grant_id)*mem_width +: mem_width];
    assign mem_read_ready  = (state == READ) && rd_ready[grant_id];
    assign rd_data         = mem_read_data;
    assign busy            = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= id_w'(num_ports - 1);
            grant_id <= '0;
            beat_cnt <= '0;
            cmd_word <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        cmd_word <= {req_write[sel_id],
                                     req_addr[32*int'(sel_id) +: 32],
                                     req_len[32*int'(sel_id) +: 32]};
                        grant_id <= sel_id;
                        rr_ptr   <= sel_id;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_cmd_ready) begin
                        beat_cnt <= cmd_word[31:0];
                        if (cmd_word[31:0] == 32'd0)
                            state <= IDLE;
                        else if (cmd_word[64])
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                WRITE: begin
                    if (mem_write_valid && mem_write_ready) begin
                        beat_cnt <= beat_cnt - 32'd1;
                        if (beat_cnt <= 32'd1)
                            state <= IDLE;
                    end
                end
                READ: begin
                    if (mem_read_valid && mem_read_ready) begin
                        beat_cnt <= beat_cnt - 32'd1;
                        if (beat_cnt <= 32'd1)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant-order table plus hand-written burst sequences.
module tb_mem_port_arbiter;
    localparam int np = 4;
    localparam int mw = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [np-1:0]    req_valid, req_ready, req_write;
    logic [32*np-1:0] req_addr, req_len;
    logic [np-1:0]    wr_valid, wr_ready, rd_valid, rd_ready;
    logic [mw*np-1:0] wr_data;
    logic [mw-1:0]    rd_data, mem_write_data, mem_read_data;
    logic             mem_cmd_valid, mem_cmd_ready;
    logic [64:0]      mem_cmd_data;
    logic             mem_write_valid, mem_write_ready;
    logic             mem_read_valid, mem_read_ready;
    logic [1:0]       grant_id;
    logic             busy;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.num_ports(np), .mem_width(mw)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_data(mem_cmd_data), .mem_cmd_ready(mem_cmd_ready),
        .mem_write_valid(mem_write_valid), .mem_write_data(mem_write_data),
        .mem_write_ready(mem_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_data(mem_read_data),
        .mem_read_ready(mem_read_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [np-1:0] rv;
        logic [np-1:0] exp_rdy;
        logic [1:0]    exp_gid;
    } gvec_t;

    gvec_t gv[8];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cmd(input int p, input logic w, input logic [31:0] a, input logic [31:0] l);
        req_write[p]        = w;
        req_addr[32*p +: 32] = a;
        req_len[32*p +: 32]  = l;
    endtask

    initial begin
        int beats;
        int p;
        logic wv, mr;

        reset = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
        wr_valid = '0; wr_data = '0; rd_ready = '0;
        mem_cmd_ready = 1'b0; mem_write_ready = 1'b0;
        mem_read_valid = 1'b0; mem_read_data = '0;

        // Reset state: outputs quiet even with requests present.
        step();
        req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_cmd_valid", mem_cmd_valid, 0);
        chk("rst_rd_ready", mem_read_ready, 0);
        step();
        req_valid = '0;
        reset = 1'b0;
        step();

        // Grant-order table: ports 0,2,3 held, then a few other mixes.
        gv[0] = '{4'b1101, 4'b0001, 2'd0};
        gv[1] = '{4'b1101, 4'b0100, 2'd2};
        gv[2] = '{4'b1101, 4'b1000, 2'd3};
        gv[3] = '{4'b1101, 4'b0001, 2'd0};
        gv[4] = '{4'b1101, 4'b0100, 2'd2};
        gv[5] = '{4'b0010, 4'b0010, 2'd1};
        gv[6] = '{4'b1001, 4'b1000, 2'd3};
        gv[7] = '{4'b1001, 4'b0001, 2'd0};
        for (int i = 0; i < np; i++) set_cmd(i, 1'b0, 32'h1000 * (i + 1), 32'd0);
        mem_cmd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = gv[i].rv;
            #1;
            chk("rr_req_ready", req_ready, gv[i].exp_rdy);
            step();
            #1;
            chk("rr_grant_id", grant_id, gv[i].exp_gid);
            chk("rr_ready_issue", req_ready, 0);
            chk("rr_cmd_data", mem_cmd_data, {1'b0, 32'h1000 * (gv[i].exp_gid + 1), 32'd0});
            step();
        end
        req_valid = '0;
        mem_cmd_ready = 1'b0;

        // Port 1 write of 4 beats.
        set_cmd(1, 1'b1, 32'h100, 32'd4);
        req_valid = 4'b0010;
        #1;
        chk("w1_req_ready", req_ready, 4'b0010);
        step();
        req_valid = '0;
        #1;
        chk("w1_cmd_valid", mem_cmd_valid, 1);
        chk("w1_cmd_data", mem_cmd_data, {1'b1, 32'h100, 32'd4});
        chk("w1_grant", grant_id, 1);
        mem_cmd_ready = 1'b1;
        step();
        mem_cmd_ready = 1'b0;
        mem_write_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            wr_valid = 4'b0010;
            wr_data[mw +: mw] = 32'hA0 + b;
            #1;
            chk("w1_wvalid", mem_write_valid, 1);
            chk("w1_wdata", mem_write_data, 32'hA0 + b);
            chk("w1_wr_ready", wr_ready, 4'b0010);
            chk("w1_busy", busy, 1);
            step();
        end
        #1;
        chk("w1_busy_end", busy, 0);
        wr_valid = '0;
        mem_write_ready = 1'b0;

        // Port 3 read of 3 beats with 5-cycle command stall.
        set_cmd(3, 1'b0, 32'h300, 32'd3);
        req_valid = 4'b1000;
        #1;
        chk("r3_req_ready", req_ready, 4'b1000);
        step();
        req_valid = '0;
        mem_read_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("r3_cmd_hold_valid", mem_cmd_valid, 1);
            chk("r3_cmd_hold_data", mem_cmd_data, {1'b0, 32'h300, 32'd3});
            chk("r3_stray_ack", mem_read_ready, 0);
            step();
        end
        mem_cmd_ready = 1'b1;
        #1;
        chk("r3_cmd_valid", mem_cmd_valid, 1);
        step();
        mem_cmd_ready = 1'b0;
        rd_ready = 4'b0111;
        mem_read_data = 32'hD0;
        #1;
        chk("r3_rd_valid_stall", rd_valid, 4'b1000);
        chk("r3_rready_stall", mem_read_ready, 0);
        step();
        rd_ready = 4'b1111;
        for (int b = 0; b < 3; b++) begin
            mem_read_data = 32'hD0 + b;
            #1;
            chk("r3_rd_valid", rd_valid, 4'b1000);
            chk("r3_rd_data", rd_data, 32'hD0 + b);
            chk("r3_rready", mem_read_ready, 1);
            chk("r3_busy", busy, 1);
            step();
        end
        #1;
        chk("r3_busy_end", busy, 0);
        chk("r3_rd_valid_idle", rd_valid, 0);
        mem_read_valid = 1'b0;
        rd_ready = '0;

        // Port 0 write of 8 beats with valid/ready gaps; other ports' wr_valid is noise.
        set_cmd(0, 1'b1, 32'h400, 32'd8);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        mem_cmd_ready = 1'b1;
        step();
        mem_cmd_ready = 1'b0;
        beats = 0;
        for (int cyc = 0; cyc < 100 && beats < 8; cyc++) begin
            wv = (cyc % 3 != 1);
            mr = (cyc % 4 != 2);
            wr_valid = {3'b111, wv};
            wr_data = {32'hEEEE, 32'hDDDD, 32'hCCCC, 32'hB00 + beats};
            mem_write_ready = mr;
            #1;
            chk("w8_busy", busy, 1);
            chk("w8_wvalid", mem_write_valid, wv);
            chk("w8_wr_ready", wr_ready, {3'b000, mr});
            if (wv && mr) begin
                chk("w8_wdata", mem_write_data, 32'hB00 + beats);
                beats++;
            end
            step();
        end
        #1;
        chk("w8_beats", beats, 8);
        chk("w8_busy_end", busy, 0);
        wr_valid = '0;
        mem_write_ready = 1'b0;

        // Port 2 zero-length read.
        set_cmd(2, 1'b0, 32'h500, 32'd0);
        req_valid = 4'b0100;
        #1;
        chk("z2_req_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        mem_cmd_ready = 1'b1;
        mem_read_valid = 1'b1;
        #1;
        chk("z2_cmd_valid", mem_cmd_valid, 1);
        chk("z2_cmd_data", mem_cmd_data, {1'b0, 32'h500, 32'd0});
        chk("z2_stray_ack", mem_read_ready, 0);
        step();
        mem_cmd_ready = 1'b0;
        #1;
        chk("z2_busy", busy, 0);
        chk("z2_cmd_valid_end", mem_cmd_valid, 0);
        chk("z2_rd_valid", rd_valid, 0);
        mem_read_valid = 1'b0;

        // Port 1 write of 6 aborted by reset during beat 2.
        set_cmd(1, 1'b1, 32'h600, 32'd6);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        mem_cmd_ready = 1'b1;
        step();
        mem_cmd_ready = 1'b0;
        mem_write_ready = 1'b1;
        wr_valid = 4'b0010;
        #1;
        chk("rs_beat1", mem_write_valid, 1);
        step();
        #1;
        chk("rs_beat2", mem_write_valid, 1);
        reset = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_wvalid", mem_write_valid, 0);
        chk("rs_wr_ready", wr_ready, 0);
        chk("rs_grant_id", grant_id, 0);
        chk("rs_req_ready", req_ready, 0);
        step();
        reset = 1'b0;
        wr_valid = '0;
        mem_write_ready = 1'b0;
        #1;
        chk("rs_first_grant", req_ready, 4'b0001);
        step();
        #1;
        chk("rs_grant_after", grant_id, 0);
        chk("rs_busy_after", busy, 1);
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
